// File: rtl/seg7_scan_capture_pkg.sv
// Shared segment table, FSM encodings and the sampled pin tuple for the seven-segment readback path.
package seg7_scan_capture_pkg;

  // Active-high gfedcba patterns, identical to the display driver's table
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  typedef struct packed {
    logic       act;
    logic [2:0] slot;
    logic [6:0] seg_n;
    logic       dp_n;
  } tuple_t;

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Display pins in, captured digit state and strobes out; master drives the pins, slave is the monitor.
interface seg7_scan_capture_if;
  logic [7:0]  AN;
  logic [6:0]  SEG_N;
  logic        DP_N;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic [7:0]  dp;
  logic        cap_pulse;
  logic        pat_err;
  logic        frame_done;

  modport master (
    output AN, SEG_N, DP_N,
    input  digits, digit_valid, dp, cap_pulse, pat_err, frame_done
  );

  modport slave (
    input  AN, SEG_N, DP_N,
    output digits, digit_valid, dp, cap_pulse, pat_err, frame_done
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational active-high gfedcba to hex nibble decode; flags table hits and the all-off pattern.
module seg7_pattern_decode
  import seg7_scan_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       is_hex,
  output logic       is_blank
);

  always_comb begin
    nibble = 4'h0;
    is_hex = 1'b1;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: is_hex = 1'b0;
    endcase
    is_blank = (seg == SEG_BLANK);
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures each settled anode slot of a scanned 7-seg display; pin edge to cap_pulse is 2+SETTLE_CYCLES+1 clocks.
// No backpressure: pins are sampled every clock and strobes are single-cycle.
module seg7_scan_capture
  import seg7_scan_capture_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input logic                CLK100MHZ,
  input logic                CPU_RESETN,
  seg7_scan_capture_if.slave bus
);

  localparam logic [7:0] FULL_MASK = 8'((1 << NUM_DIGITS) - 1);
  localparam logic [7:0] SETTLE_W  = 8'(SETTLE_CYCLES);

  logic [NUM_DIGITS-1:0] an_m, an_s;
  logic [6:0]            seg_m, seg_s;
  logic                  dp_m, dp_s;

  // Sync flops idle at "all pins off" so reset release never looks like a strobe
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      an_m  <= '1;
      an_s  <= '1;
      seg_m <= '1;
      seg_s <= '1;
      dp_m  <= 1'b1;
      dp_s  <= 1'b1;
    end else begin
      an_m  <= bus.AN[NUM_DIGITS-1:0];
      an_s  <= an_m;
      seg_m <= bus.SEG_N;
      seg_s <= seg_m;
      dp_m  <= bus.DP_N;
      dp_s  <= dp_m;
    end
  end

  logic [3:0] low_cnt;
  logic [2:0] slot_idx;
  logic       slot_act;
  tuple_t     cur_tup, tup_q;
  logic       changed;

  always_comb begin
    low_cnt  = 4'd0;
    slot_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_s[i]) begin
        low_cnt  = low_cnt + 4'd1;
        slot_idx = 3'(i);
      end
    end
    slot_act      = (low_cnt == 4'd1);
    cur_tup.act   = slot_act;
    cur_tup.slot  = slot_act ? slot_idx : 3'd0;
    cur_tup.seg_n = seg_s;
    cur_tup.dp_n  = dp_s;
    changed       = (cur_tup != tup_q);
  end

  state_t     state, state_nx;
  logic [7:0] cnt;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) state <= ST_IDLE;
    else             state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:    if (cur_tup.act) state_nx = ST_SETTLE;
      ST_SETTLE: begin
        if (changed || !cur_tup.act) state_nx = ST_IDLE;
        else if (cnt == SETTLE_W)    state_nx = ST_CAPTURE;
      end
      ST_CAPTURE: state_nx = ST_HOLD;
      ST_HOLD:    if (changed) state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  // cnt counts consecutive identical samples of the tuple latched on SETTLE entry
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      cnt   <= 8'd0;
      tup_q <= '0;
    end else if (state == ST_IDLE && cur_tup.act) begin
      cnt   <= 8'd1;
      tup_q <= cur_tup;
    end else if (state == ST_SETTLE && state_nx == ST_IDLE) begin
      cnt <= 8'd0;
    end else if (state == ST_SETTLE && cnt < SETTLE_W) begin
      cnt <= cnt + 8'd1;
    end
  end

  logic [6:0] seg_hi;
  logic [3:0] nibble;
  logic       is_hex, is_blank;

  assign seg_hi = ~tup_q.seg_n;

  seg7_pattern_decode u_decode (
    .seg      (seg_hi),
    .nibble   (nibble),
    .is_hex   (is_hex),
    .is_blank (is_blank)
  );

  logic [7:0] mask_q, mask_nx, slot_bit;
  logic       cap, err, fdone;

  always_comb begin
    slot_bit = 8'd1 << tup_q.slot;
    mask_nx  = mask_q | slot_bit;
    cap      = 1'b0;
    err      = 1'b0;
    fdone    = 1'b0;
    if (state == ST_CAPTURE) begin
      cap   = 1'b1;
      err   = !is_hex && !is_blank;
      fdone = ((mask_nx & FULL_MASK) == FULL_MASK);
    end
  end

  logic [31:0] digits_q;
  logic [7:0]  valid_q, dp_q;

  // Only slots below NUM_DIGITS are ever written, so the upper bits stay at their reset 0
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      digits_q <= 32'd0;
      valid_q  <= 8'd0;
      dp_q     <= 8'd0;
      mask_q   <= 8'd0;
    end else if (cap) begin
      if (is_hex) digits_q[{tup_q.slot, 2'b00} +: 4] <= nibble;
      valid_q[tup_q.slot] <= is_hex;
      dp_q[tup_q.slot]    <= ~tup_q.dp_n;
      mask_q              <= fdone ? 8'd0 : mask_nx;
    end
  end

  assign bus.digits      = digits_q;
  assign bus.digit_valid = valid_q;
  assign bus.dp          = dp_q;
  assign bus.cap_pulse   = cap;
  assign bus.pat_err     = err;
  assign bus.frame_done  = fdone;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed table plus randomized segment sequences checked against a transaction-level display model.
module tb_seg7_scan_capture;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_capture_if bus();

  seg7_scan_capture #(.NUM_DIGITS(4), .SETTLE_CYCLES(16)) dut (
    .CLK100MHZ  (clk),
    .CPU_RESETN (rst_n),
    .bus        (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cap_cnt  = 0;
  int err_cnt  = 0;
  int fd_cnt   = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      cap_cnt += int'(bus.cap_pulse);
      err_cnt += int'(bus.pat_err);
      fd_cnt  += int'(bus.frame_done);
    end
  end

  typedef struct {
    logic [7:0]  an;
    logic [6:0]  seg_n;
    logic        dp_n;
    int          hold;
    logic [15:0] exp_dig;
    logic [3:0]  exp_val;
    logic [3:0]  exp_dp;
    int          d_cap;
    int          d_err;
    int          d_fd;
  } vec_t;

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] an, input logic [6:0] seg_n, input logic dp_n);
    bus.AN    = an;
    bus.SEG_N = seg_n;
    bus.DP_N  = dp_n;
  endtask

  function automatic logic [6:0] pin(input logic [6:0] p);
    return ~p;
  endfunction

  function automatic logic [50:0] all_outs();
    return {bus.digits, bus.digit_valid, bus.dp, bus.cap_pulse, bus.pat_err, bus.frame_done};
  endfunction

  vec_t       vt [11];
  int         c0, e0, f0, lat;
  logic [3:0] m_dig [4];
  logic [3:0] m_val, m_dp, m_mask;
  int         x_cap, x_err, x_fd;
  logic [7:0] r_an;
  logic [6:0] r_seg, prev_seg;
  logic       r_dp, r_long, r_act;
  int         r_len, r_slot, r_hit, lows;

  initial begin
    vt[0]  = '{8'hFE, pin(7'h06), 1'b1, 200, 16'h0001, 4'b0001, 4'b0000, 1, 0, 0};
    vt[1]  = '{8'hFD, pin(7'h5B), 1'b1, 200, 16'h0021, 4'b0011, 4'b0000, 1, 0, 0};
    vt[2]  = '{8'hFB, pin(7'h4F), 1'b1, 200, 16'h0321, 4'b0111, 4'b0000, 1, 0, 0};
    vt[3]  = '{8'hF7, pin(7'h66), 1'b1, 200, 16'h4321, 4'b1111, 4'b0000, 1, 0, 1};
    vt[4]  = '{8'hFC, pin(7'h06), 1'b1, 100, 16'h4321, 4'b1111, 4'b0000, 0, 0, 0};
    vt[5]  = '{8'hFD, pin(7'h49), 1'b1, 100, 16'h4321, 4'b1101, 4'b0000, 1, 1, 0};
    vt[6]  = '{8'hFD, 7'h7F,      1'b1, 100, 16'h4321, 4'b1101, 4'b0000, 1, 0, 0};
    vt[7]  = '{8'hFE, pin(7'h7F), 1'b0, 100, 16'h4328, 4'b1101, 4'b0001, 1, 0, 0};
    vt[8]  = '{8'hFB, pin(7'h77), 1'b0, 100, 16'h4A28, 4'b1101, 4'b0101, 1, 0, 0};
    vt[9]  = '{8'hF7, pin(7'h71), 1'b1, 100, 16'hFA28, 4'b1101, 4'b0101, 1, 0, 1};
    vt[10] = '{8'hFF, pin(7'h3F), 1'b1,  50, 16'hFA28, 4'b1101, 4'b0101, 0, 0, 0};

    // Reset held with random pins
    drive(8'hFF, 7'h7F, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive(8'($urandom), 7'($urandom), 1'($urandom));
      cyc(3);
      chk("reset_outputs", 64'(all_outs()), 64'd0);
    end
    drive(8'hFF, 7'($urandom), 1'($urandom));
    rst_n = 1'b1;
    c0 = cap_cnt;
    cyc(1000);
    chk("idle_no_capture", 64'(cap_cnt - c0), 64'd0);

    // Exact capture latency on a steady slot 0
    c0 = cap_cnt;
    drive(8'hFE, pin(7'h4F), 1'b0);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.cap_pulse) lat = k;
    end
    chk("latency", 64'(lat), 64'd19);
    cyc(11);
    chk("t2_digit0", 64'(bus.digits[3:0]), 64'h3);
    chk("t2_valid0", 64'(bus.digit_valid[0]), 64'd1);
    chk("t2_dp0", 64'(bus.dp[0]), 64'd1);
    chk("t2_one_cap", 64'(cap_cnt - c0), 64'd1);
    cyc(60);
    chk("t2_no_recapture", 64'(cap_cnt - c0), 64'd1);

    for (int i = 0; i < 11; i++) begin
      c0 = cap_cnt; e0 = err_cnt; f0 = fd_cnt;
      drive(vt[i].an, vt[i].seg_n, vt[i].dp_n);
      cyc(vt[i].hold);
      chk($sformatf("vec%0d_digits", i), 64'(bus.digits[15:0]), 64'(vt[i].exp_dig));
      chk($sformatf("vec%0d_digits_hi", i), 64'(bus.digits[31:16]), 64'd0);
      chk($sformatf("vec%0d_valid", i), 64'(bus.digit_valid), 64'(vt[i].exp_val));
      chk($sformatf("vec%0d_dp", i), 64'(bus.dp), 64'(vt[i].exp_dp));
      chk($sformatf("vec%0d_caps", i), 64'(cap_cnt - c0), 64'(vt[i].d_cap));
      chk($sformatf("vec%0d_errs", i), 64'(err_cnt - e0), 64'(vt[i].d_err));
      chk($sformatf("vec%0d_frames", i), 64'(fd_cnt - f0), 64'(vt[i].d_fd));
    end

    // Pattern toggling faster than the settle window never captures
    c0 = cap_cnt;
    for (int i = 0; i < 20; i++) begin
      drive(8'hFB, (i % 2 == 0) ? pin(7'h39) : pin(7'h5E), 1'b1);
      cyc(10);
    end
    drive(8'hFF, 7'h7F, 1'b1);
    cyc(20);
    chk("toggle_no_capture", 64'(cap_cnt - c0), 64'd0);
    chk("toggle_digits", 64'(bus.digits), 64'h0000FA28);

    // Reset in the middle of slot 2's settle window
    c0 = cap_cnt;
    drive(8'hFE, pin(7'h3F), 1'b1);
    cyc(40);
    drive(8'hFD, pin(7'h06), 1'b1);
    cyc(40);
    chk("t6_two_caps", 64'(cap_cnt - c0), 64'd2);
    drive(8'hFB, pin(7'h5B), 1'b1);
    cyc(10);
    rst_n = 1'b0;
    #1;
    chk("t6_async_reset", 64'(all_outs()), 64'd0);
    cyc(1);
    chk("t6_reset_edge", 64'(all_outs()), 64'd0);
    drive(8'hFF, 7'h7F, 1'b1);
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    f0 = fd_cnt;
    drive(8'hFE, pin(7'h06), 1'b1); cyc(40);
    drive(8'hFD, pin(7'h5B), 1'b1); cyc(40);
    drive(8'hFB, pin(7'h4F), 1'b1); cyc(40);
    drive(8'hF7, pin(7'h66), 1'b1); cyc(40);
    chk("t6_one_frame", 64'(fd_cnt - f0), 64'd1);
    chk("t6_digits", 64'(bus.digits), 64'h00004321);
    chk("t6_valid", 64'(bus.digit_valid), 64'h0F);

    // Randomized segments against the display model
    m_dig[0] = 4'h1; m_dig[1] = 4'h2; m_dig[2] = 4'h3; m_dig[3] = 4'h4;
    m_val = 4'b1111; m_dp = 4'b0000; m_mask = 4'b0000;
    x_cap = 0; x_err = 0; x_fd = 0;
    c0 = cap_cnt; e0 = err_cnt; f0 = fd_cnt;
    prev_seg = pin(7'h66);
    for (int s = 0; s < 80; s++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: r_an = {4'hF, ~(4'b0001 << $urandom_range(0, 3))};
        7:                   r_an = 8'hFF;
        default:             r_an = {4'hF, 4'($urandom)};
      endcase
      do begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: r_seg = ~tbl[$urandom_range(0, 15)];
          6:                r_seg = 7'h7F;
          default:          r_seg = 7'($urandom);
        endcase
      end while (r_seg == prev_seg);
      prev_seg = r_seg;
      r_dp   = 1'($urandom);
      r_long = ($urandom_range(0, 2) != 0);
      r_len  = r_long ? int'($urandom_range(30, 50)) : int'($urandom_range(3, 12));
      drive(r_an, r_seg, r_dp);
      cyc(r_len);

      lows = 0; r_slot = 0;
      for (int b = 0; b < 4; b++) if (!r_an[b]) begin lows++; r_slot = b; end
      r_act = (lows == 1);
      if (r_long && r_act) begin
        x_cap++;
        r_hit = -1;
        for (int p = 0; p < 16; p++) if (tbl[p] == ~r_seg) r_hit = p;
        if (r_hit >= 0) begin
          m_dig[r_slot] = 4'(r_hit);
          m_val[r_slot] = 1'b1;
        end else begin
          m_val[r_slot] = 1'b0;
          if (r_seg != 7'h7F) x_err++;
        end
        m_dp[r_slot]   = ~r_dp;
        m_mask[r_slot] = 1'b1;
        if (m_mask == 4'b1111) begin
          x_fd++;
          m_mask = 4'b0000;
        end
      end
      chk($sformatf("rnd%0d_digits", s), 64'(bus.digits),
          64'({16'h0, m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
      chk($sformatf("rnd%0d_valid", s), 64'(bus.digit_valid), 64'({4'h0, m_val}));
      chk($sformatf("rnd%0d_dp", s), 64'(bus.dp), 64'({4'h0, m_dp}));
      chk($sformatf("rnd%0d_caps", s), 64'(cap_cnt - c0), 64'(x_cap));
      chk($sformatf("rnd%0d_errs", s), 64'(err_cnt - e0), 64'(x_err));
      chk($sformatf("rnd%0d_frames", s), 64'(fd_cnt - f0), 64'(x_fd));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
